// File: rtl/router_pkg.sv
// Shared router definitions: default widths, header field layout, FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

    // Default data-path geometry.
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;
    localparam int NUM_CH_DEF = 3;
    localparam int CNT_W_DEF  = 16;

    // Header layout: destination address in the LSBs, payload length above it.
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = ADDR_W_DEF;

    // Router FSM state encodings, shared with the input FSM.
    localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] ST_LOAD_DATA          = 3'd2;
    localparam logic [2:0] ST_LOAD_PARITY        = 3'd3;
    localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd6;
    localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd7;

endpackage

// File: rtl/router_parity_chk.sv
// Packet parity and payload-length checker for the router data-path register.
// Latency: err/len_err/pkt_good resolve one cycle after parity_done rises.
// Backpressure: payload stalled by a full FIFO is counted once, on first load.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hdr_cap,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              fifo_full,
    input  logic              pkt_valid,
    input  logic              low_pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] hdr,
    output logic              parity_done,
    output logic              err,
    output logic              len_err,
    output logic              pkt_good
);
    localparam int LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] int_parity;
    logic [DATA_W-1:0] ext_parity;
    logic [LEN_W-1:0]  len_cnt;
    logic              parity_done_q;
    logic              chk;
    logic              par_ok;
    logic              len_ok;

    // The check fires exactly once, on the first cycle parity_done is seen high.
    assign chk      = parity_done & ~parity_done_q;
    assign par_ok   = (int_parity == ext_parity);
    assign len_ok   = (len_cnt == hdr[DATA_W-1:ADDR_W]);
    assign pkt_good = chk & ~hdr_cap & par_ok & len_ok;

    // Running parity over header and payload, plus saturating payload count.
    always_ff @(posedge clk) begin
        if (reset || hdr_cap) begin
            int_parity <= '0;
            len_cnt    <= '0;
        end else if (lfd_state) begin
            int_parity <= int_parity ^ hdr;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity <= int_parity ^ data_in;
            if (len_cnt != '1) begin
                len_cnt <= len_cnt + 1'b1;
            end
        end
    end

    // Trailing parity byte is captured whenever it arrives, even into a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_parity <= '0;
        end else if (ld_state && !pkt_valid) begin
            ext_parity <= data_in;
        end
    end

    // parity_done waits for the FIFO to accept the parity byte (directly or via LAF).
    always_ff @(posedge clk) begin
        if (reset || hdr_cap) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    // Delayed copy of parity_done for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_done_q <= 1'b0;
        end else begin
            parity_done_q <= parity_done;
        end
    end

    // Error flags are evaluated once per packet and held until the next header.
    always_ff @(posedge clk) begin
        if (reset || hdr_cap) begin
            err     <= 1'b0;
            len_err <= 1'b0;
        end else if (chk) begin
            err     <= ~par_ok;
            len_err <= ~len_ok;
        end
    end

endmodule

// File: rtl/router_reg_param.sv
// Router data-path register: header latch, payload forwarding, parity/length check.
// Latency: dout is registered, one cycle behind data_in; status one cycle after parity.
// Backpressure: one byte parked in hold_byte while the FIFO is full, replayed in LAF.
module router_reg_param
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic              fifo_full,
    input  logic              detect_addr,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              lfd_state,
    input  logic              rst_int_reg,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] dout,
    output logic              err,
    output logic              len_err,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic [CNT_W-1:0]  pkt_count
);
    localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W+1)'(NUM_CH);

    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] hold_byte;
    logic              hdr_cap;
    logic              pkt_good;

    // A header is only taken for a channel that exists; others are left to the FSM.
    assign hdr_cap = detect_addr & pkt_valid & ({1'b0, data_in[ADDR_W-1:0]} < NUM_CH_L);

    // Header latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr <= '0;
        end else if (hdr_cap) begin
            hdr <= data_in;
        end
    end

    // Output byte: header first, then payload, then the parked byte after a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (lfd_state) begin
            dout <= hdr;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (laf_state) begin
            dout <= hold_byte;
        end
    end

    // Park the byte that arrived while the FIFO was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_byte <= '0;
        end else if (ld_state && fifo_full) begin
            hold_byte <= data_in;
        end
    end

    // Source has ended the packet; the clear from the FSM takes precedence.
    always_ff @(posedge clk) begin
        if (reset || rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    // Good-packet counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (pkt_good && (pkt_count != '1)) begin
            pkt_count <= pkt_count + 1'b1;
        end
    end

    router_parity_chk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_parity_chk (
        .clk           (clk),
        .reset         (reset),
        .hdr_cap       (hdr_cap),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .fifo_full     (fifo_full),
        .pkt_valid     (pkt_valid),
        .low_pkt_valid (low_pkt_valid),
        .data_in       (data_in),
        .hdr           (hdr),
        .parity_done   (parity_done),
        .err           (err),
        .len_err       (len_err),
        .pkt_good      (pkt_good)
    );

endmodule

// File: tb/tb_router_reg_param.sv
// Directed bench for router_reg_param: 8-bit default build plus a 16-bit build.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: fifo_full stalls driven explicitly per scenario.
module tb_router_reg_param;
    import router_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 8-bit DUT signals
    logic        pkt_valid = 1'b0, fifo_full = 1'b0, detect_addr = 1'b0, ld_state = 1'b0;
    logic        laf_state = 1'b0, full_state = 1'b0, lfd_state = 1'b0, rst_int_reg = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  dout;
    logic        err, len_err, parity_done, low_pkt_valid;
    logic [15:0] pkt_count;

    // 16-bit DUT signals (2-bit counter to reach saturation quickly)
    logic        w_pkt_valid = 1'b0, w_fifo_full = 1'b0, w_detect_addr = 1'b0, w_ld_state = 1'b0;
    logic        w_laf_state = 1'b0, w_full_state = 1'b0, w_lfd_state = 1'b0, w_rst_int_reg = 1'b0;
    logic [15:0] w_data_in = 16'h0000;
    logic [15:0] w_dout;
    logic        w_err, w_len_err, w_parity_done, w_low_pkt_valid;
    logic [1:0]  w_pkt_count;

    int checks = 0;
    int errors = 0;

    router_reg_param dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_addr(detect_addr), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .lfd_state(lfd_state), .rst_int_reg(rst_int_reg),
        .data_in(data_in), .dout(dout), .err(err), .len_err(len_err),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .pkt_count(pkt_count)
    );

    router_reg_param #(.DATA_W(16), .ADDR_W(2), .NUM_CH(3), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .pkt_valid(w_pkt_valid), .fifo_full(w_fifo_full),
        .detect_addr(w_detect_addr), .ld_state(w_ld_state), .laf_state(w_laf_state),
        .full_state(w_full_state), .lfd_state(w_lfd_state), .rst_int_reg(w_rst_int_reg),
        .data_in(w_data_in), .dout(w_dout), .err(w_err), .len_err(w_len_err),
        .parity_done(w_parity_done), .low_pkt_valid(w_low_pkt_valid), .pkt_count(w_pkt_count)
    );

    // One clock of 8-bit stimulus: FSM state, pkt_valid, fifo_full, data, rst_int_reg.
    task automatic cyc(input logic [2:0] st, input logic pv, input logic ff,
                       input logic [7:0] d, input logic rir);
        detect_addr = (st == ST_DECODE_ADDRESS);
        lfd_state   = (st == ST_LOAD_FIRST_DATA);
        ld_state    = (st == ST_LOAD_DATA);
        full_state  = (st == ST_FIFO_FULL_STATE);
        laf_state   = (st == ST_LOAD_AFTER_FULL);
        pkt_valid   = pv;
        fifo_full   = ff;
        data_in     = d;
        rst_int_reg = rir;
        @(posedge clk);
        #1;
    endtask

    // One clock of 16-bit stimulus.
    task automatic wcyc(input logic [2:0] st, input logic pv, input logic ff,
                        input logic [15:0] d, input logic rir);
        w_detect_addr = (st == ST_DECODE_ADDRESS);
        w_lfd_state   = (st == ST_LOAD_FIRST_DATA);
        w_ld_state    = (st == ST_LOAD_DATA);
        w_full_state  = (st == ST_FIFO_FULL_STATE);
        w_laf_state   = (st == ST_LOAD_AFTER_FULL);
        w_pkt_valid   = pv;
        w_fifo_full   = ff;
        w_data_in     = d;
        w_rst_int_reg = rir;
        @(posedge clk);
        #1;
    endtask

    // Header, first-data and n payload bytes 1..n with the FIFO never full.
    task automatic drive_hdr_payload(input logic [7:0] h, input int n);
        cyc(ST_DECODE_ADDRESS, 1'b1, 1'b0, h, 1'b0);
        cyc(ST_LOAD_FIRST_DATA, 1'b1, 1'b0, 8'h01, 1'b0);
        for (int i = 1; i <= n; i++) cyc(ST_LOAD_DATA, 1'b1, 1'b0, 8'(i), 1'b0);
    endtask

    task automatic test_reset;
        cyc(ST_WAIT_TILL_EMPTY, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(ST_WAIT_TILL_EMPTY, 1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
        checks++; if (err !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", err, len_err); end
        checks++; if (parity_done !== 1'b0 || low_pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", parity_done, low_pkt_valid); end
        checks++; if (pkt_count !== 16'd0 || w_pkt_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d/%0d exp 0/0", pkt_count, w_pkt_count); end
    endtask

    // Header 0x01: addr 1, length 0; parity is the header itself.
    task automatic test_zero_len;
        cyc(ST_DECODE_ADDRESS, 1'b1, 1'b0, 8'h01, 1'b0);
        cyc(ST_LOAD_FIRST_DATA, 1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL zl_hdr_dout got %h exp 01", dout); end
        cyc(ST_LOAD_DATA, 1'b0, 1'b0, 8'h01, 1'b0);
        checks++; if (parity_done !== 1'b1 || low_pkt_valid !== 1'b1) begin errors++; $display("FAIL zl_done got %b%b exp 11", parity_done, low_pkt_valid); end
        cyc(ST_CHECK_PARITY_ERROR, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (err !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL zl_err got %b%b exp 00", err, len_err); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL zl_count got %0d exp 1", pkt_count); end
    endtask

    task automatic test_reset_mid_packet;
        drive_hdr_payload(8'h21, 2);
        checks++; if (dout !== 8'h02) begin errors++; $display("FAIL mid_dout got %h exp 02", dout); end
        checks++; if (parity_done !== 1'b0 || low_pkt_valid !== 1'b1) begin errors++; $display("FAIL mid_flags got %b%b exp 01", parity_done, low_pkt_valid); end
        reset = 1'b1;
        cyc(ST_LOAD_DATA, 1'b1, 1'b0, 8'h03, 1'b0);
        cyc(ST_LOAD_DATA, 1'b0, 1'b0, 8'h04, 1'b0);
        reset = 1'b0;
        checks++; if (dout !== 8'h00 || err !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL rst_mid_out got %h %b%b exp 00 00", dout, err, len_err); end
        checks++; if (parity_done !== 1'b0 || low_pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got %b%b exp 00", parity_done, low_pkt_valid); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", pkt_count); end
        cyc(ST_WAIT_TILL_EMPTY, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Header 0x21 (len 8, addr 1), payload 01..08, parity 0x29.
    task automatic test_good_packet;
        cyc(ST_DECODE_ADDRESS, 1'b1, 1'b0, 8'h21, 1'b0);
        cyc(ST_LOAD_FIRST_DATA, 1'b1, 1'b0, 8'h01, 1'b0);
        checks++; if (dout !== 8'h21) begin errors++; $display("FAIL good_hdr got %h exp 21", dout); end
        for (int i = 1; i <= 8; i++) begin
            cyc(ST_LOAD_DATA, 1'b1, 1'b0, 8'(i), 1'b0);
            checks++; if (dout !== 8'(i) || parity_done !== 1'b0) begin errors++; $display("FAIL good_byte%0d got %h/%b exp %h/0", i, dout, parity_done, 8'(i)); end
        end
        cyc(ST_LOAD_DATA, 1'b0, 1'b0, 8'h29, 1'b0);
        checks++; if (dout !== 8'h29 || parity_done !== 1'b1) begin errors++; $display("FAIL good_par got %h/%b exp 29/1", dout, parity_done); end
        cyc(ST_CHECK_PARITY_ERROR, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (err !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL good_err got %b%b exp 00", err, len_err); end
        checks++; if (pkt_count !== 16'd1 || low_pkt_valid !== 1'b0) begin errors++; $display("FAIL good_count got %0d/%b exp 1/0", pkt_count, low_pkt_valid); end
    endtask

    task automatic test_bad_parity;
        drive_hdr_payload(8'h21, 8);
        cyc(ST_LOAD_DATA, 1'b0, 1'b0, 8'h28, 1'b0);
        cyc(ST_CHECK_PARITY_ERROR, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (err !== 1'b1 || len_err !== 1'b0) begin errors++; $display("FAIL badpar_err got %b%b exp 10", err, len_err); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL badpar_count got %0d exp 1", pkt_count); end
        cyc(ST_WAIT_TILL_EMPTY, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badpar_hold got %b exp 1", err); end
        cyc(ST_DECODE_ADDRESS, 1'b1, 1'b0, 8'h21, 1'b0);
        checks++; if (err !== 1'b0 || parity_done !== 1'b0) begin errors++; $display("FAIL badpar_clr got %b%b exp 00", err, parity_done); end
    endtask

    // 7 payload bytes against a length of 8; parity 0x21 is correct for them.
    task automatic test_short_payload;
        drive_hdr_payload(8'h21, 7);
        cyc(ST_LOAD_DATA, 1'b0, 1'b0, 8'h21, 1'b1);
        checks++; if (parity_done !== 1'b1 || low_pkt_valid !== 1'b0) begin errors++; $display("FAIL short_flags got %b%b exp 10", parity_done, low_pkt_valid); end
        cyc(ST_CHECK_PARITY_ERROR, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (err !== 1'b0 || len_err !== 1'b1) begin errors++; $display("FAIL short_err got %b%b exp 01", err, len_err); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL short_count got %0d exp 1", pkt_count); end
    endtask

    task automatic test_fifo_full_mid;
        drive_hdr_payload(8'h21, 2);
        cyc(ST_LOAD_DATA, 1'b1, 1'b1, 8'h03, 1'b0);
        checks++; if (dout !== 8'h02) begin errors++; $display("FAIL full_stall1 got %h exp 02", dout); end
        cyc(ST_FIFO_FULL_STATE, 1'b1, 1'b1, 8'h03, 1'b0);
        checks++; if (dout !== 8'h02) begin errors++; $display("FAIL full_stall2 got %h exp 02", dout); end
        cyc(ST_LOAD_AFTER_FULL, 1'b1, 1'b0, 8'h03, 1'b0);
        checks++; if (dout !== 8'h03 || parity_done !== 1'b0) begin errors++; $display("FAIL full_laf got %h/%b exp 03/0", dout, parity_done); end
        for (int i = 4; i <= 8; i++) cyc(ST_LOAD_DATA, 1'b1, 1'b0, 8'(i), 1'b0);
        checks++; if (dout !== 8'h08) begin errors++; $display("FAIL full_last got %h exp 08", dout); end
        cyc(ST_LOAD_DATA, 1'b0, 1'b0, 8'h29, 1'b0);
        cyc(ST_CHECK_PARITY_ERROR, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (err !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL full_err got %b%b exp 00", err, len_err); end
        checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL full_count got %0d exp 2", pkt_count); end
    endtask

    // Header 0x05 (len 1, addr 1), payload 0x33, parity 0x36 arriving into a full FIFO.
    task automatic test_parity_while_full;
        cyc(ST_DECODE_ADDRESS, 1'b1, 1'b0, 8'h05, 1'b0);
        cyc(ST_LOAD_FIRST_DATA, 1'b1, 1'b0, 8'h33, 1'b0);
        cyc(ST_LOAD_DATA, 1'b1, 1'b0, 8'h33, 1'b0);
        cyc(ST_LOAD_DATA, 1'b0, 1'b1, 8'h36, 1'b0);
        checks++; if (parity_done !== 1'b0 || low_pkt_valid !== 1'b1 || dout !== 8'h33) begin errors++; $display("FAIL pfull_ld got %b%b %h exp 01 33", parity_done, low_pkt_valid, dout); end
        cyc(ST_FIFO_FULL_STATE, 1'b0, 1'b1, 8'h36, 1'b0);
        checks++; if (parity_done !== 1'b0) begin errors++; $display("FAIL pfull_wait got %b exp 0", parity_done); end
        cyc(ST_LOAD_AFTER_FULL, 1'b0, 1'b0, 8'h36, 1'b0);
        checks++; if (parity_done !== 1'b1 || dout !== 8'h36) begin errors++; $display("FAIL pfull_laf got %b %h exp 1 36", parity_done, dout); end
        cyc(ST_CHECK_PARITY_ERROR, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (err !== 1'b0 || len_err !== 1'b0 || pkt_count !== 16'd3) begin errors++; $display("FAIL pfull_chk got %b%b %0d exp 00 3", err, len_err, pkt_count); end
    endtask

    // Address 3 is out of range: the previous header (0x05) must survive.
    task automatic test_invalid_addr;
        cyc(ST_DECODE_ADDRESS, 1'b1, 1'b0, 8'h23, 1'b0);
        cyc(ST_LOAD_FIRST_DATA, 1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (dout !== 8'h05) begin errors++; $display("FAIL inv_hdr got %h exp 05", dout); end
        checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL inv_count got %0d exp 3", pkt_count); end
        cyc(ST_WAIT_TILL_EMPTY, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // 16-bit build: header 0x0041 (len 16, addr 1), words 1..16, parity 0x0051,
    // then zero-length packets to push the 2-bit counter into saturation.
    task automatic test_wide;
        logic [1:0] exp_w [3];
        exp_w[0] = 2'd2; exp_w[1] = 2'd3; exp_w[2] = 2'd3;
        wcyc(ST_DECODE_ADDRESS, 1'b1, 1'b0, 16'h0041, 1'b0);
        wcyc(ST_LOAD_FIRST_DATA, 1'b1, 1'b0, 16'h0001, 1'b0);
        checks++; if (w_dout !== 16'h0041) begin errors++; $display("FAIL wide_hdr got %h exp 0041", w_dout); end
        for (int i = 1; i <= 16; i++) wcyc(ST_LOAD_DATA, 1'b1, 1'b0, 16'(i), 1'b0);
        checks++; if (w_dout !== 16'h0010) begin errors++; $display("FAIL wide_last got %h exp 0010", w_dout); end
        wcyc(ST_LOAD_DATA, 1'b0, 1'b0, 16'h0051, 1'b0);
        wcyc(ST_CHECK_PARITY_ERROR, 1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (w_err !== 1'b0 || w_len_err !== 1'b0 || w_pkt_count !== 2'd1) begin errors++; $display("FAIL wide_chk got %b%b %0d exp 00 1", w_err, w_len_err, w_pkt_count); end
        for (int p = 0; p < 3; p++) begin
            wcyc(ST_DECODE_ADDRESS, 1'b1, 1'b0, 16'h0001, 1'b0);
            wcyc(ST_LOAD_FIRST_DATA, 1'b1, 1'b0, 16'h0000, 1'b0);
            wcyc(ST_LOAD_DATA, 1'b0, 1'b0, 16'h0001, 1'b0);
            wcyc(ST_CHECK_PARITY_ERROR, 1'b0, 1'b0, 16'h0000, 1'b1);
            checks++; if (w_pkt_count !== exp_w[p]) begin errors++; $display("FAIL wide_sat%0d got %0d exp %0d", p, w_pkt_count, exp_w[p]); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_reset_mid_packet();
        test_good_packet();
        test_bad_parity();
        test_short_payload();
        test_fifo_full_mid();
        test_parity_while_full();
        test_invalid_addr();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/router_reg_param.md
Name: router_reg_param

Overview:
- Parametrised next-generation router data-path register between the input FSM and the per-channel output FIFOs.
- Latches the header, forwards payload to the FIFO, and holds one byte while the FIFO is full.
- Accumulates packet parity and compares it with the trailing parity byte.
- New behaviour over the fixed-width version: configurable data width and channel count, a payload-length check against the header length field, and a saturating good-packet counter.

Parameters:
- DATA_W, 8, data bus width (min 4)
- ADDR_W, 2, header address field width (LSBs of the header)
- NUM_CH, 3, valid channel count; header addr >= NUM_CH is a dropped packet
- CNT_W, 16, width of good-packet counter
- Derived localparam LEN_W = DATA_W-ADDR_W, header length field (MSBs)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  source packet valid
- fifo_full  in  1  selected FIFO full
- detect_addr  in  1  FSM in DECODE_ADDRESS
- ld_state  in  1  FSM in LOAD_DATA
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- full_state  in  1  FSM in FIFO_FULL_STATE
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- rst_int_reg  in  1  clears low_pkt_valid
- data_in  in  DATA_W  incoming byte
- dout  out  DATA_W  byte to FIFO
- err  out  1  parity mismatch
- len_err  out  1  payload count != header length
- parity_done  out  1  parity byte received
- low_pkt_valid  out  1  pkt_valid has dropped
- pkt_count  out  CNT_W  good packets (no err, no len_err)

Behaviour:
- Priority in every register: reset > detect_addr clear > load actions.
- Reset: all outputs and internal registers go to 0 on the next rising edge, including mid-packet.
- Header capture:
  - detect_addr & pkt_valid & addr<NUM_CH: hdr <= data_in.
  - The same condition clears int_parity, len_cnt, parity_done, err and len_err.
- dout, registered with 1-cycle latency:
  - lfd_state: dout <= hdr.
  - ld_state & !fifo_full: dout <= data_in.
  - ld_state & fifo_full: hold_byte <= data_in; dout holds.
  - laf_state: dout <= hold_byte.
  - Otherwise dout holds.
- Internal parity:
  - lfd_state: int_parity ^= hdr.
  - ld_state & pkt_valid & !full_state: int_parity ^= data_in; len_cnt++.
  - len_cnt saturates at 2^LEN_W-1.
- Packet parity: ld_state & !pkt_valid latches ext_parity <= data_in.
- low_pkt_valid:
  - Set on ld_state & !pkt_valid.
  - Cleared by reset or rst_int_reg (clear wins if simultaneous).
- parity_done:
  - Set on (ld_state & !fifo_full & !pkt_valid) or (laf_state & low_pkt_valid & !parity_done).
  - Cleared only by reset or detect_addr.
- Check, the cycle after parity_done rises:
  - err <= (int_parity != ext_parity).
  - len_err <= (len_cnt != hdr[DATA_W-1:ADDR_W]).
  - If both are 0, pkt_count++ (saturates at all-ones, never wraps).
  - err and len_err hold until the next detect_addr or reset.
- Zero-length header (len=0): the first ld_state byte with pkt_valid low is parity; len_cnt=0 matches, no len_err.
- Invalid addr: header is not latched; no state changes; FSM is responsible for discarding.
- fifo_full while ld_state with pkt_valid low: the parity byte is still latched; parity_done waits for laf_state.

Decomposition:
- Shared package router_pkg: DATA_W/ADDR_W defaults, header field slice localparams, FSM state encodings shared with the router FSM.
- One natural sub-module, router_parity_chk: int/ext parity registers, len_cnt, err/len_err generation.
- Top level keeps the dout/hold path, low_pkt_valid and pkt_count.

Test Plan:
- Reset held 2 cycles mid-packet -> next cycle dout=0, err=0, len_err=0, parity_done=0, low_pkt_valid=0, pkt_count=0.
- Header 8'h21 (len 8, addr 1), payload 8'h01..8'h08, parity 8'h29, fifo_full=0 -> dout follows data with 1-cycle lag, parity_done=1 after parity byte, err=0, len_err=0, pkt_count=1.
- Same packet with parity byte 8'h28 -> err=1, len_err=0, pkt_count unchanged.
- Header 8'h21 but only 7 payload bytes, correct parity over those bytes -> err=0, len_err=1, pkt_count unchanged.
- fifo_full=1 on the 3rd payload byte (8'h03) for 2 cycles, then laf_state -> dout stalls, then dout=8'h03; parity still 8'h29 expected and err=0.
- Header 8'h23 (addr 3 with NUM_CH=3) -> hdr unchanged; DATA_W=16 build: header 16'h0041, 16 words, correct parity -> err=0, pkt_count=1.
